// File: rtl/control_cmd_dumprow.sv
// Row readback engine: streams the row address byte, then every pixel byte of that row
// (column and byte-select both descending), in the same order the row-load command consumes them.
module control_cmd_dumprow #(
  parameter int unsigned BYTES_PER_PIXEL = 2,
  parameter int unsigned PIXEL_WIDTH     = 64,
  parameter int unsigned ROW_WIDTH       = 5,
  localparam int unsigned COL_W = (PIXEL_WIDTH > 1) ? $clog2(PIXEL_WIDTH) : 1,
  localparam int unsigned PIX_W = (BYTES_PER_PIXEL > 1) ? $clog2(BYTES_PER_PIXEL) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ROW_WIDTH-1:0] row_in,
  output logic [ROW_WIDTH-1:0] row,
  output logic [COL_W-1:0]     column,
  output logic [PIX_W-1:0]     pixel,
  output logic                 ram_read_enable,
  input  logic [7:0]           ram_data,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 busy,
  output logic                 done
);

  localparam logic [COL_W-1:0] ColMax = COL_W'(PIXEL_WIDTH - 1);
  localparam logic [PIX_W-1:0] PixMax = PIX_W'(BYTES_PER_PIXEL - 1);

  typedef enum logic [2:0] {StIdle, StHeader, StIssue, StWait, StSend, StDone} state_e;

  state_e state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= StIdle;
      row             <= '0;
      column          <= '0;
      pixel           <= '0;
      tx_data         <= '0;
      tx_valid        <= 1'b0;
      ram_read_enable <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      ram_read_enable <= 1'b0;
      done            <= 1'b0;
      case (state)
        StIdle: begin
          if (start) begin
            row      <= row_in;
            column   <= ColMax;
            pixel    <= PixMax;
            tx_data  <= 8'(row_in);
            tx_valid <= 1'b1;
            busy     <= 1'b1;
            state    <= StHeader;
          end
        end
        StHeader: begin
          if (tx_ready) begin
            tx_valid        <= 1'b0;
            ram_read_enable <= 1'b1;
            state           <= StIssue;
          end
        end
        StIssue: state <= StWait;
        StWait: begin
          tx_data  <= ram_data;
          tx_valid <= 1'b1;
          state    <= StSend;
        end
        StSend: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            // Terminal test uses the pre-decrement counters so nothing ever wraps.
            if (column == '0 && pixel == '0) begin
              done  <= 1'b1;
              state <= StDone;
            end else begin
              if (pixel == '0) begin
                pixel  <= PixMax;
                column <= column - 1'b1;
              end else begin
                pixel <= pixel - 1'b1;
              end
              ram_read_enable <= 1'b1;
              state           <= StIssue;
            end
          end
        end
        StDone: begin
          busy  <= 1'b0;
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_control_cmd_dumprow.sv
// Randomized bench for control_cmd_dumprow: a queue-based model of the expected byte/read stream
// is checked every cycle, plus literal expectations for the directed cases.
module tb_control_cmd_dumprow;

  localparam int PW  = 4;
  localparam int BPP = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, tx_ready;
  logic [4:0] row_in;
  logic [7:0] ram_data;
  logic [4:0] row;
  logic [1:0] column;
  logic [0:0] pixel;
  logic       ram_read_enable, tx_valid, busy, done;
  logic [7:0] tx_data;

  logic       start1, tx_ready1;
  logic [4:0] row_in1, row1;
  logic [7:0] ram_data1, tx_data1;
  logic [0:0] column1, pixel1;
  logic       ram_read_enable1, tx_valid1, busy1, done1;

  control_cmd_dumprow #(.BYTES_PER_PIXEL(BPP), .PIXEL_WIDTH(PW), .ROW_WIDTH(5)) dut (
    .clk(clk), .reset(reset), .start(start), .row_in(row_in), .row(row), .column(column),
    .pixel(pixel), .ram_read_enable(ram_read_enable), .ram_data(ram_data), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .done(done)
  );

  control_cmd_dumprow #(.BYTES_PER_PIXEL(1), .PIXEL_WIDTH(1), .ROW_WIDTH(5)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .row_in(row_in1), .row(row1), .column(column1),
    .pixel(pixel1), .ram_read_enable(ram_read_enable1), .ram_data(ram_data1),
    .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready1), .busy(busy1), .done(done1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  bit lit_mode  = 1'b1;
  bit rand_ready = 1'b0;

  // RAM contents: literal mode is {column, pixel}; otherwise mixed with the row.
  function automatic logic [7:0] fdata(input logic [4:0] r, input int c, input int p);
    logic [7:0] h;
    h = {c[3:0], p[3:0]};
    if (!lit_mode) h = h ^ (8'(r) * 8'd37);
    return h;
  endfunction

  always @(posedge clk) if (ram_read_enable) ram_data <= fdata(row, int'(column), int'(pixel));
  always @(posedge clk) if (ram_read_enable1) ram_data1 <= fdata(row1, int'(column1), int'(pixel1));

  always @(posedge clk) begin
    #1;
    if (rand_ready) tx_ready = 1'($urandom_range(0, 1));
  end

  // Reference model state
  bit          chk_en = 1'b0;
  int          cyc = 0;
  bit          active = 1'b0;
  int          done_due = -10;
  int          start_cyc = 0;
  int          dump_len = 0;
  int          n_reads = 0;
  int          n_done = 0;
  logic [7:0]  exp_bytes[$];
  logic [23:0] exp_rd[$];
  logic [7:0]  log_b[$];
  bit          prev_pend = 1'b0;
  logic [7:0]  prev_data;

  always @(negedge clk) begin
    if (reset && chk_en) begin
      cyc++;
      chk("rd_with_valid", 32'(tx_valid & ram_read_enable), 0);
      if (prev_pend) begin
        chk("hold_valid", 32'(tx_valid), 1);
        chk("hold_data", 32'(tx_data), 32'(prev_data));
      end
      prev_pend = tx_valid && !tx_ready;
      prev_data = tx_data;
      chk("busy", 32'(busy), 32'(active));
      chk("done", 32'(done), 32'(active && cyc == done_due));
      if (!active) chk("idle_valid", 32'(tx_valid), 0);
      if (ram_read_enable) begin
        n_reads++;
        if (exp_rd.size() == 0) chk("rd_unexpected", exp_rd.size(), 1);
        else chk("rd_addr", {8'(row), 8'(column), 8'(pixel)}, 32'(exp_rd.pop_front()));
      end
      if (tx_valid && tx_ready) begin
        if (exp_bytes.size() == 0) chk("byte_unexpected", exp_bytes.size(), 1);
        else begin
          chk("byte", 32'(tx_data), 32'(exp_bytes.pop_front()));
          log_b.push_back(tx_data);
          if (exp_bytes.size() == 0) done_due = cyc + 1;
        end
      end
      if (done) begin
        n_done++;
        dump_len = cyc - start_cyc;
      end
      if (active && cyc == done_due) begin
        chk("done_rd_left", exp_rd.size(), 0);
        active = 1'b0;
      end else if (!active && start) begin
        active    = 1'b1;
        start_cyc = cyc;
        done_due  = -10;
        exp_bytes.push_back(8'(row_in));
        for (int c = PW - 1; c >= 0; c--) begin
          for (int p = BPP - 1; p >= 0; p--) begin
            exp_bytes.push_back(fdata(row_in, c, p));
            exp_rd.push_back({8'(row_in), 8'(c), 8'(p)});
          end
        end
      end
    end
  end

  task automatic do_start(input logic [4:0] r);
    start  = 1'b1;
    row_in = r;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int prev);
    int k = 0;
    while (n_done == prev && k < 2000) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk("done_timeout", n_done, prev + 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_row"}, 32'(row), 0);
    chk({tag, "_column"}, 32'(column), 0);
    chk({tag, "_pixel"}, 32'(pixel), 0);
    chk({tag, "_tx_data"}, 32'(tx_data), 0);
    chk({tag, "_tx_valid"}, 32'(tx_valid), 0);
    chk({tag, "_rd_en"}, 32'(ram_read_enable), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
  endtask

  task automatic chk_lit5(input string tag);
    logic [7:0] lit5 [9];
    lit5 = '{8'h05, 8'h31, 8'h30, 8'h21, 8'h20, 8'h11, 8'h10, 8'h01, 8'h00};
    chk({tag, "_nbytes"}, log_b.size(), 9);
    for (int i = 0; i < 9 && i < log_b.size(); i++) chk({tag, "_lit"}, 32'(log_b[i]), 32'(lit5[i]));
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int d0, k, rd1, pixnz1, done1_at, both1;
    logic [7:0] log1[$];

    reset = 1'b0; start = 1'b0; row_in = '0; tx_ready = 1'b1;
    start1 = 1'b0; row_in1 = '0; tx_ready1 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("rst");
    reset  = 1'b1;
    chk_en = 1'b1;
    @(posedge clk); #1;

    // Directed: row 5, ready held high
    log_b.delete(); n_reads = 0; d0 = n_done;
    do_start(5);
    wait_done(d0);
    repeat (2) @(posedge clk);
    #1;
    chk_lit5("t1");
    chk("t1_latency", dump_len, 26);
    chk("t1_reads", n_reads, 8);
    chk("t1_row_hold", 32'(row), 5);
    chk("t1_col_hold", 32'(column), 0);
    chk("t1_pix_hold", 32'(pixel), 0);

    // Directed: 1x1 instance, row 7
    log1.delete(); rd1 = 0; pixnz1 = 0; done1_at = -1; both1 = 0;
    start1 = 1'b1; row_in1 = 7;
    @(negedge clk);
    @(posedge clk); #1;
    start1 = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (ram_read_enable1) begin
        rd1++;
        chk("t7_rd_addr", {8'(row1), 8'(column1), 8'(pixel1)}, 32'h070000);
      end
      if (pixel1 != 0) pixnz1++;
      if (tx_valid1 && ram_read_enable1) both1++;
      if (tx_valid1 && tx_ready1) log1.push_back(tx_data1);
      if (done1) done1_at = i;
    end
    chk("t7_nbytes", log1.size(), 2);
    if (log1.size() == 2) begin
      chk("t7_byte0", 32'(log1[0]), 32'h07);
      chk("t7_byte1", 32'(log1[1]), 32'h00);
    end
    chk("t7_reads", rd1, 1);
    chk("t7_pixel", pixnz1, 0);
    chk("t7_rd_valid", both1, 0);
    chk("t7_latency", done1_at, 5);

    // Directed: random backpressure, row 5
    @(posedge clk); #1;
    log_b.delete(); n_reads = 0; d0 = n_done; rand_ready = 1'b1;
    do_start(5);
    wait_done(d0);
    rand_ready = 1'b0; tx_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_lit5("t2");
    chk("t2_reads", n_reads, 8);

    // Directed: start pulsed mid-dump and in the done cycle
    log_b.delete(); d0 = n_done;
    do_start(5);
    repeat (5) @(posedge clk);
    #1;
    start = 1'b1; row_in = 3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    start = 1'b1; row_in = 3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("t3_dones", n_done, d0 + 1);
    chk_lit5("t3");
    chk("t3_busy", 32'(busy), 0);

    // Directed: asynchronous reset while a byte is pending in SEND
    log_b.delete(); d0 = n_done;
    do_start(5);
    k = 0;
    while (log_b.size() < 3 && k < 200) begin @(posedge clk); #1; k++; end
    tx_ready = 1'b0;
    k = 0;
    while (!tx_valid && k < 50) begin @(posedge clk); #1; k++; end
    chk("t4_pending", 32'(tx_valid), 1);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk_reset_outputs("t4_async");
    exp_bytes.delete(); exp_rd.delete();
    active = 1'b0; prev_pend = 1'b0; done_due = -10;
    tx_ready = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;
    log_b.delete();
    repeat (6) @(posedge clk);
    #1;
    chk("t4_no_bytes", log_b.size(), 0);
    chk("t4_no_done", n_done, d0);
    do_start(2);
    wait_done(d0);
    repeat (2) @(posedge clk);
    #1;
    chk("t4_nbytes", log_b.size(), 9);
    if (log_b.size() > 0) chk("t4_first", 32'(log_b[0]), 32'h02);

    // Randomized dumps with hashed RAM contents and random backpressure
    lit_mode = 1'b0; rand_ready = 1'b1;
    for (int it = 0; it < 8; it++) begin
      log_b.delete(); d0 = n_done;
      do_start(5'($urandom_range(0, 31)));
      wait_done(d0);
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
      chk("rnd_nbytes", log_b.size(), 9);
    end
    rand_ready = 1'b0; tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/control_cmd_dumprow.md
# control_cmd_dumprow

Row readback engine for the control path. On a start pulse it streams one display row out of frame RAM as a byte sequence: the row address byte, then every pixel byte in the exact order the row-load command consumes them. A host can therefore read back a row and replay it byte-for-byte as a row-load payload. It sits between the frame RAM read port and the UART transmitter byte interface.

## Interface
Parameters:
- BYTES_PER_PIXEL, default params::BYTES_PER_PIXEL: bytes per pixel; must be ≥1.
- PIXEL_WIDTH, default params::PIXEL_WIDTH: pixels per row; must be ≥1.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  input  1  sole clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low; asserting it (low) clears all state immediately, independent of clk.
- start  input  1  single-cycle request; sampled only in IDLE.
- row_in  input  types::row_addr_t  row to dump; captured on an accepted start.
- row  output  types::row_addr_t  RAM read row address.
- column  output  types::col_addr_t  RAM read column address.
- pixel  output  calc::num_pixelcolorselect_bits(BYTES_PER_PIXEL)  RAM read byte select within the pixel.
- ram_read_enable  output  1  one-cycle RAM read strobe.
- ram_data  input  8  RAM read data; valid exactly 1 cycle after ram_read_enable.
- tx_data  output  8  byte to the transmitter.
- tx_valid  output  1  tx_data holds a byte.
- tx_ready  input  1  transmitter accepts the byte.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse after the final byte is accepted.

## Operation
- Byte sequence, N = 1 + PIXEL_WIDTH*BYTES_PER_PIXEL bytes:
  - Byte 0: the captured row, zero-extended to 8 bits.
  - Then the pixel bytes. Column runs PIXEL_WIDTH-1 down to 0 (outer loop). Pixel runs BYTES_PER_PIXEL-1 down to 0 (inner loop).
- Transfer rule: a byte is transferred on any cycle where tx_valid=1 and tx_ready=1.
  - While tx_valid=1 and tx_ready=0, tx_data must hold steady and tx_valid must stay high.
- States:
  - IDLE:
    - On start=1: row ← row_in, column ← PIXEL_WIDTH-1, pixel ← BYTES_PER_PIXEL-1, tx_data ← row byte, tx_valid ← 1; go to HEADER.
    - If start=0: no change.
  - HEADER: on transfer, tx_valid ← 0; go to ISSUE.
  - ISSUE: ram_read_enable=1 for exactly this cycle, with the current row/column/pixel; go to WAIT.
  - WAIT: tx_data ← ram_data, tx_valid ← 1; go to SEND.
  - SEND: on transfer, tx_valid ← 0, then:
    - If column=0 and pixel=0, go to DONE.
    - Else if pixel=0: pixel ← BYTES_PER_PIXEL-1, column ← column-1; go to ISSUE.
    - Else: pixel ← pixel-1; go to ISSUE.
  - DONE: done=1 for one cycle; go to IDLE.
- row/column/pixel hold their last values in IDLE. After a full dump they read row/0/0.
- start is ignored whenever busy=1; no queuing.
- Counter arithmetic: column and pixel never underflow. The terminal test (column=0 and pixel=0) is evaluated before any decrement.
- BYTES_PER_PIXEL=1: pixel stays 0; column alone steps.
- PIXEL_WIDTH=1: exactly BYTES_PER_PIXEL reads.

## Timing
- Reset values: row=0, column=0, pixel=0, tx_data=0, tx_valid=0, ram_read_enable=0, busy=0, done=0; state=IDLE.
- Reset asserted mid-dump: the dump aborts; all outputs go to reset values. No done pulse is emitted, and no further bytes are emitted after release.
- Latency:
  - start to first tx_valid: 1 cycle.
  - Per pixel byte with tx_ready held high: 3 cycles (ISSUE, WAIT, SEND).
  - Full dump with tx_ready always high: 2 + 3*(N-1) cycles from the start edge to the DONE cycle.
- ram_read_enable and tx_valid are never high in the same cycle.
- Exactly one RAM read is issued per pixel byte.
- done is asserted the cycle after the final transfer. busy falls together with done's deassertion.
- A start arriving in the same cycle as done is ignored.

## Test plan
- PIXEL_WIDTH=4, BYTES_PER_PIXEL=2, RAM model returns {column[3:0],pixel[3:0]}, tx_ready=1, start with row_in=5:
  - Bytes 05,31,30,21,20,11,10,01,00.
  - done occurs 26 cycles after start.
  - 8 read strobes.
- Same setup, tx_ready toggled pseudo-randomly:
  - Identical byte stream.
  - tx_data is stable on every cycle with valid=1 and ready=0.
  - No read is issued while a byte is pending.
- start pulsed again mid-dump and in the done cycle:
  - Both ignored.
  - Exactly 9 bytes and one done pulse.
- reset driven low asynchronously mid-SEND:
  - Outputs go to reset values without a clock edge.
  - After release, a fresh start with row_in=2 produces a full 9-byte dump beginning with 02.
- BYTES_PER_PIXEL=1, PIXEL_WIDTH=1, row_in=7:
  - Bytes 07,00.
  - One read strobe; pixel stays 0.
  - done occurs 5 cycles after start.
